// File: rtl/nrs_slot_scheduler_rx_if.sv
// nrs_slot_scheduler_rx_if: strobe/resync inputs and position outputs of the NRS slot scheduler
interface nrs_slot_scheduler_rx_if #(
  parameter int RUNS_PER_SLOT = 2,
  parameter int SLOTS_PER_SF  = 2,
  parameter int NUM_SF        = 10,
  parameter int SFN_W         = 10
);
  localparam int RUN_W  = $clog2(RUNS_PER_SLOT * SLOTS_PER_SF);
  localparam int RIS_W  = $clog2(RUNS_PER_SLOT);
  localparam int SF_W   = $clog2(NUM_SF);
  localparam int SLOT_W = $clog2(NUM_SF * SLOTS_PER_SF);
  logic              cinit_run;
  logic              sync_load;
  logic [SF_W-1:0]   sync_sf;
  logic [SFN_W-1:0]  sync_sfn;
  logic              active;
  logic [RUN_W-1:0]  run_in_sf;
  logic [RIS_W-1:0]  run_in_slot;
  logic [SLOT_W-1:0] slot;
  logic [SF_W-1:0]   subframe;
  logic [SFN_W-1:0]  sfn;
  logic              first_run;
  logic              last_run;
  logic              frame_wrap;
  logic              sync_err;
  modport master (
    output cinit_run, sync_load, sync_sf, sync_sfn,
    input  active, run_in_sf, run_in_slot, slot, subframe, sfn, first_run, last_run, frame_wrap, sync_err
  );
  modport slave (
    input  cinit_run, sync_load, sync_sf, sync_sfn,
    output active, run_in_sf, run_in_slot, slot, subframe, sfn, first_run, last_run, frame_wrap, sync_err
  );
endinterface

// File: rtl/nrs_slot_scheduler_rx.sv
// nrs_slot_scheduler_rx: run/slot/subframe/frame sequencer that skips subframes carrying no NRS
module nrs_slot_scheduler_rx #(
  parameter int                RUNS_PER_SLOT  = 2,
  parameter int                SLOTS_PER_SF   = 2,
  parameter int                NUM_SF         = 10,
  parameter logic [NUM_SF-1:0] SKIP_MASK      = 10'b0000100000,
  parameter logic [NUM_SF-1:0] SKIP_EVEN_MASK = 10'b1000000000,
  parameter int                SFN_W          = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  nrs_slot_scheduler_rx_if.slave  bus
);
  localparam int RUNS_PER_SF = RUNS_PER_SLOT * SLOTS_PER_SF;
  localparam int RUN_W       = $clog2(RUNS_PER_SF);
  localparam int RIS_W       = $clog2(RUNS_PER_SLOT);
  localparam int SF_W        = $clog2(NUM_SF);
  localparam int SLOT_W      = $clog2(NUM_SF * SLOTS_PER_SF);
  logic             active;
  logic [RUN_W-1:0] r;
  logic [SF_W-1:0]  sf;
  logic [SFN_W-1:0] sfn;
  logic             frame_wrap;
  logic             sync_err;
  logic             last;
  logic             sync_ok;
  logic [SF_W:0]    nv_adv;
  logic [SF_W:0]    nv_sync;
  // MSB set means no valid subframe remains in this frame; subframe 0 of the next frame is always valid
  function automatic logic [SF_W:0] next_valid(input logic [SF_W:0] s, input logic odd);
    logic [SF_W-1:0] k;
    next_valid = {1'b1, {SF_W{1'b0}}};
    for (int i = 0; i < NUM_SF; i++) begin
      k = SF_W'(NUM_SF - 1 - i);
      if ({1'b0, k} >= s && !SKIP_MASK[k] && !(SKIP_EVEN_MASK[k] && !odd)) next_valid = {1'b0, k};
    end
  endfunction
  always_comb begin
    last    = r == RUN_W'(RUNS_PER_SF - 1);
    sync_ok = {1'b0, bus.sync_sf} < (SF_W+1)'(NUM_SF);
    nv_adv  = next_valid((SF_W+1)'(sf) + (SF_W+1)'(1), sfn[0]);
    nv_sync = next_valid({1'b0, bus.sync_sf}, bus.sync_sfn[0]);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      active     <= 1'b0;
      r          <= '0;
      sf         <= '0;
      sfn        <= '0;
      frame_wrap <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      frame_wrap <= 1'b0;
      sync_err   <= bus.sync_load && !sync_ok;
      if (bus.sync_load) begin
        if (sync_ok) begin
          active <= 1'b1;
          r      <= '0;
          sf     <= nv_sync[SF_W-1:0];
          sfn    <= bus.sync_sfn + SFN_W'(nv_sync[SF_W]);
        end
      end else if (bus.cinit_run) begin
        if (!active) begin
          active <= 1'b1;
          r      <= '0;
          sf     <= '0;
          sfn    <= '0;
        end else if (!last) begin
          r <= r + RUN_W'(1);
        end else begin
          r          <= '0;
          sf         <= nv_adv[SF_W-1:0];
          sfn        <= sfn + SFN_W'(nv_adv[SF_W]);
          frame_wrap <= nv_adv[SF_W];
        end
      end
    end
  assign bus.active      = active;
  assign bus.run_in_sf   = r;
  assign bus.run_in_slot = RIS_W'(int'(r) % RUNS_PER_SLOT);
  assign bus.slot        = SLOT_W'(int'(sf) * SLOTS_PER_SF + int'(r) / RUNS_PER_SLOT);
  assign bus.subframe    = sf;
  assign bus.sfn         = sfn;
  assign bus.first_run   = active && r == '0 && sf == '0;
  assign bus.last_run    = active && last;
  assign bus.frame_wrap  = frame_wrap;
  assign bus.sync_err    = sync_err;
endmodule
